// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// register-address constants and the enable/flush bundle that the
// pipeline-register blocks consume.
package pipe_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // Enable/flush bundle driven to the PC and the four pipeline registers.
    typedef struct packed {
        logic pc_we;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Normal flow: everything advances, nothing is bubbled.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_we: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_flush: 1'b0, exmem_en: 1'b1, memwb_flush: 1'b0
    };

    // Whole pipeline holds while MEM is stuck; WB receives a bubble.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_we: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
        idex_flush: 1'b0, exmem_en: 1'b0, memwb_flush: 1'b1
    };

    // Held while reset is asserted: nothing loads, every flush is active.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_we: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
        idex_flush: 1'b1, exmem_en: 1'b0, memwb_flush: 1'b1
    };

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// that the instruction in ID reads. Writes to $zero never create a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             lu
);

    logic dst_nonzero;
    logic rs_match;
    logic rt_match;

    // Compare the load destination against both ID source operands.
    always_comb begin
        dst_nonzero = (ex_rt != REG_W'(REG_ZERO));
        rs_match    = (ex_rt == id_rs);
        rt_match    = id_uses_rt && (ex_rt == id_rt);
        lu          = ex_mem_read && dst_nonzero && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Priority in RUN: memory wait > taken branch > load-use stall.
// Optional perf counters (stall_cycles, flush_events) are built only when
// HAZ_PERF_CNT_EN is defined; otherwise both ports are tied to zero.
//
// Memory handshake: mem_req marks the MEM instruction as a data access and
// stays high while it is held; the access completes in the cycle where
// mem_req && mem_ready. mem_ready without mem_req carries no meaning.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = REG_W_DEFAULT,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_wait_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             lu;
    logic             mem_wait;
    logic             mem_err_c;
    pipe_ctrl_t       ctrl;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu          (lu)
    );

    assign mem_wait     = mem_req && !mem_ready;
    // wait_cnt is 0 in RUN, so the same increment counts the first wait cycle.
    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    // Next-state and same-cycle hazard response from state and inputs.
    always_comb begin
        ctrl       = CTRL_RUN;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_c  = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_inc;
                    state_d    = (wait_cnt_inc >= TIMEOUT_C) ? ERROR : MEM_WAIT;
                end else begin
                    // Access done (or none): apply any branch/LU held in EX/ID now.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (ex_branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (lu) begin
                        ctrl.pc_we      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end
                end
            end
            ERROR: begin
                ctrl      = CTRL_FREEZE;
                mem_err_c = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (!reset) begin
            ctrl      = CTRL_RESET;
            mem_err_c = 1'b0;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign memwb_flush  = ctrl.memwb_flush;
    assign mem_err      = mem_err_c;
    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wait_cnt_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Count frozen-PC cycles and cycles that bubble IF/ID or ID/EX.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ~ctrl.pc_we};
        flush_events_d = flush_events_q + {31'd0, (ctrl.ifid_flush | ctrl.idex_flush)};
    end

    // Counter registers; reset holds them at zero so reset cycles never count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver pushes the hand-computed
// response for each cycle into exp_q; a monitor pops and compares on the
// falling edge. Built with MEM_TIMEOUT=4 so the timeout path is short.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int TO    = 4;
    localparam int CNT_W = 8;
    localparam int W     = 18;

    // Control bundle order: pc_we ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_RST = 7'b0010101;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MW  = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic             mem_err;
    logic [31:0]      stall_cycles, flush_events;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_wait_cnt;

    logic [W-1:0] exp_q[$];
    string        nm_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_we           (pc_we),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_flush     (memwb_flush),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .dbg_state       (dbg_state),
        .dbg_wait_cnt    (dbg_wait_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(logic [6:0] c, logic err, logic [1:0] st, logic [CNT_W-1:0] cnt);
        return {c, err, st, cnt};
    endfunction

    task automatic set_in(int rs, int rt, logic uses_rt, logic mrd, int ert,
                          logic br, logic req, logic rdy);
        id_rs           = REG_W'(rs);
        id_rt           = REG_W'(rt);
        id_uses_rt      = uses_rt;
        ex_mem_read     = mrd;
        ex_rt           = REG_W'(ert);
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
    endtask

    // Queue this cycle's expected response, then advance past the next edge.
    task automatic step(string nm, logic [W-1:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic check32(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        string        nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {pc_we, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                       memwb_flush, mem_err, dbg_state, dbg_wait_cnt};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b err=%b st=%0d cnt=%0d, expected ctl=%b err=%b st=%0d cnt=%0d",
                             nm, act[17:11], act[10], act[9:8], act[7:0],
                             e[17:11], e[10], e[9:8], e[7:0]);
                end
            end
        end
    end

    // Driver: directed vectors.
    initial begin
        int drain;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        step("reset_hold", ev(C_RST, 0, S_RUN, 0));
        check32("reset_stall_cnt", stall_cycles, 0);
        reset = 1'b1;
        step("idle", ev(C_DEF, 0, S_RUN, 0));

        // Load-use on rs: one bubble, then defaults.
        set_in(8, 1, 0, 1, 8, 0, 0, 0);
        step("lu_rs", ev(C_LU, 0, S_RUN, 0));
        set_in(8, 1, 0, 0, 8, 0, 0, 0);
        step("lu_after", ev(C_DEF, 0, S_RUN, 0));

        // Masked hazards: $zero destination, rt not used.
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        step("lu_zero", ev(C_DEF, 0, S_RUN, 0));
        set_in(3, 9, 0, 1, 9, 0, 0, 0);
        step("lu_rt_unused", ev(C_DEF, 0, S_RUN, 0));
        set_in(3, 9, 1, 1, 9, 0, 0, 0);
        step("lu_rt_used", ev(C_LU, 0, S_RUN, 0));

        // Branch wins over a simultaneous load-use.
        set_in(8, 1, 0, 1, 8, 1, 0, 0);
        step("br_and_lu", ev(C_BR, 0, S_RUN, 0));
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        step("br_only", ev(C_BR, 0, S_RUN, 0));

        // mem_ready without mem_req is ignored.
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        step("rdy_no_req", ev(C_DEF, 0, S_RUN, 0));

        // Three wait cycles, then completion.
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("mw_1", ev(C_FRZ, 0, S_RUN, 0));
        step("mw_2", ev(C_FRZ, 0, S_MW, 1));
        step("mw_3", ev(C_FRZ, 0, S_MW, 2));
        mem_ready = 1'b1;
        step("mw_done", ev(C_DEF, 0, S_MW, 3));
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_back_run", ev(C_DEF, 0, S_RUN, 0));

        // Branch held frozen in EX is applied on the completing cycle.
        set_in(0, 0, 0, 0, 0, 1, 1, 0);
        step("mw_br_frz", ev(C_FRZ, 0, S_RUN, 0));
        mem_ready = 1'b1;
        step("mw_br_done", ev(C_BR, 0, S_MW, 1));

        // Load-use held in ID/EX is applied on the completing cycle.
        set_in(5, 0, 0, 1, 5, 0, 1, 0);
        step("mw_lu_frz", ev(C_FRZ, 0, S_RUN, 0));
        mem_ready = 1'b1;
        step("mw_lu_done", ev(C_LU, 0, S_MW, 1));

        // Timeout after the 4th wait cycle, sticky until reset.
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("to_1", ev(C_FRZ, 0, S_RUN, 0));
        step("to_2", ev(C_FRZ, 0, S_MW, 1));
        step("to_3", ev(C_FRZ, 0, S_MW, 2));
        step("to_4", ev(C_FRZ, 0, S_MW, 3));
        step("err_a", ev(C_FRZ, 1, S_ERR, 4));
        set_in(0, 0, 0, 0, 0, 1, 1, 1);
        step("err_sticky", ev(C_FRZ, 1, S_ERR, 4));
        reset = 1'b0;
        step("err_reset", ev(C_RST, 0, S_RUN, 0));
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("err_release", ev(C_DEF, 0, S_RUN, 0));

        // Async reset between edges in MEM_WAIT.
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("ar_1", ev(C_FRZ, 0, S_RUN, 0));
        step("ar_2", ev(C_FRZ, 0, S_MW, 1));
        reset = 1'b0;
        step("ar_reset", ev(C_RST, 0, S_RUN, 0));
`ifdef HAZ_PERF_CNT_EN
        check32("perf_stall_rst", stall_cycles, 0);
        check32("perf_flush_rst", flush_events, 0);
`endif
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("ar_release", ev(C_DEF, 0, S_RUN, 0));

        // Frozen-cycle count after reset.
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        step("pc_1", ev(C_FRZ, 0, S_RUN, 0));
        step("pc_2", ev(C_FRZ, 0, S_MW, 1));
        step("pc_3", ev(C_FRZ, 0, S_MW, 2));
        mem_ready = 1'b1;
        step("pc_done", ev(C_DEF, 0, S_MW, 3));
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        step("pc_br", ev(C_BR, 0, S_RUN, 0));
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
        check32("perf_stall", stall_cycles, 3);
        check32("perf_flush", flush_events, 1);
`else
        check32("perf_stall_tied", stall_cycles, 0);
        check32("perf_flush_tied", flush_events, 0);
`endif

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives enable/flush of the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
- Resolves load-use hazards, taken branches (resolved in EX) and multi-cycle data-memory accesses in MEM.
- Detects memory timeout and parks the pipeline in a sticky error state.

Parameters:
REG_W, 5, register-address width
MEM_TIMEOUT, 255, max consecutive wait cycles before error (1..2^CNT_W-1)
CNT_W, 8, wait-counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  load destination in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads a bubble
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads a bubble
exmem_en  out  1  EX/MEM load enable
memwb_flush  out  1  MEM/WB loads a bubble
mem_err  out  1  sticky timeout flag
stall_cycles  out  32  perf counter (optional feature)
flush_events  out  32  perf counter (optional feature)

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Registered state plus wait_cnt[CNT_W-1:0]. Outputs are combinational from state and inputs.
- Reset (reset=0, async):
  - state=RUN, wait_cnt=0, mem_err=0, counters=0.
  - While reset is held: pc_we, ifid_en, idex_en, exmem_en = 0; ifid_flush, idex_flush, memwb_flush = 1.
  - Reset mid-wait or in ERROR returns to RUN.
- Defaults: all enables=1, all flushes=0.
- Load-use hazard (LU): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Priority in RUN: memory wait > branch > LU.
  - mem_req && !mem_ready:
    - pc_we = ifid_en = idex_en = exmem_en = 0; memwb_flush = 1.
    - Next state MEM_WAIT, wait_cnt = 1.
  - else ex_branch_taken:
    - ifid_flush = idex_flush = 1; pc_we = 1 (target).
    - Stays in RUN. Exactly one flush cycle per taken branch.
  - else LU:
    - pc_we = ifid_en = 0; idex_flush = 1.
    - Exactly one bubble; the next cycle the load is in MEM and LU is false.
- LU and a taken branch in the same cycle: branch wins. The ID instruction is flushed, so no stall.
- MEM_WAIT:
  - mem_ready=0: freeze as above, wait_cnt++.
  - If wait_cnt == MEM_TIMEOUT while still not ready, go to ERROR.
  - mem_ready=1: outputs equal RUN evaluation with mem_req treated as satisfied. A branch or LU held frozen in EX/ID is applied in this same cycle. Next state RUN, wait_cnt=0.
- ERROR:
  - mem_err = 1; full freeze (all enables 0, memwb_flush = 1).
  - Leaves only on reset.
- mem_ready without mem_req is ignored.
- Latency: hazard response is same-cycle combinational; state updates on the next edge.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - stall_cycles increments on every cycle in which pc_we=0 and reset=1.
  - flush_events increments on every cycle with ifid_flush=1 or idex_flush=1 while reset=1.
  - Both wrap at 2^32.
- Undefined: both ports tied to 0 and the counter logic is not built.

Decomposition:
- Package pipe_ctrl_pkg:
  - State enum (RUN, MEM_WAIT, ERROR).
  - REG_W default.
  - REG_ZERO constant (5'd0).
  - Enable/flush bundle struct shared with the pipeline-register blocks.
- One natural sub-module: load_use_detect, purely combinational, producing LU from id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt.

Test Plan:
- Load-use stall: ex_mem_read=1, ex_rt=8, id_rs=8 in RUN → one cycle of pc_we=0, ifid_en=0, idex_flush=1. The next cycle (ex_mem_read=0) returns to defaults.
- Hazard masked by $zero or unused rt: ex_rt=0, id_rs=0 → no stall. ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
- Taken branch with simultaneous LU: ex_branch_taken=1 and LU → ifid_flush=1, idex_flush=1, pc_we=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → full freeze plus memwb_flush=1 for 3 cycles, normal on the 4th. State returns to RUN and wait_cnt=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_err=1 after the 4th wait cycle and remains 1. reset=0 → mem_err=0, state RUN.
- Async reset mid-MEM_WAIT: pull reset low between edges → outputs take reset values immediately. With HAZ_PERF_CNT_EN, counters read 0 after reset and stall_cycles equals the number of frozen cycles.
